// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - two-requester arbiter for the shared synchronous RAM port
// Optional round-robin tie-breaking is enabled by defining MEM_ARB_RR_EN;
// without it requester 0 always wins a tie.
module mem_port_arbiter #(
  parameter int AW = 9,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [2:0]    m0_cmd,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_ready,
  output logic          m0_rvalid,
  output logic [DW-1:0] m0_rdata,
  input  logic [2:0]    m1_cmd,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_ready,
  output logic          m1_rvalid,
  output logic [DW-1:0] m1_rdata,
  output logic [2:0]    mem_cmd,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam logic [2:0] MNONE  = 3'b001;
  localparam logic [2:0] MREAD  = 3'b010;
  localparam logic [2:0] MWRITE = 3'b100;

  typedef enum logic [1:0] {S_IDLE, S_ACC, S_RESP} state_t;

  state_t state, state_nxt;
  logic   owner;
  logic   req0, req1;
  logic   grant0, grant1;
  logic   accept;

  // Only the two legal one-hot access codes count as a request.
  assign req0 = (m0_cmd == MREAD) || (m0_cmd == MWRITE);
  assign req1 = (m1_cmd == MREAD) || (m1_cmd == MWRITE);

`ifdef MEM_ARB_RR_EN
  logic rr_last;

  // Remember the most recent grant so a tie goes to the other requester.
  always_ff @(posedge clk) begin
    if (reset)
      rr_last <= 1'b1;
    else if (accept)
      rr_last <= grant1;
  end

  assign grant0 = req0 && (!req1 || rr_last);
`else
  assign grant0 = req0;
`endif
  assign grant1 = req1 && !grant0;

  // Next-state and grant decode; grants only happen from idle and never during reset.
  always_comb begin
    state_nxt = state;
    m0_ready  = 1'b0;
    m1_ready  = 1'b0;
    accept    = 1'b0;
    case (state)
      S_IDLE: begin
        if (!reset && (grant0 || grant1)) begin
          accept    = 1'b1;
          m0_ready  = grant0;
          m1_ready  = grant1;
          state_nxt = S_ACC;
        end
      end
      S_ACC:   state_nxt = (mem_cmd == MREAD) ? S_RESP : S_IDLE;
      S_RESP:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // State plus the registered RAM command/address/data; the command lives for one cycle only.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      mem_cmd   <= MNONE;
      mem_addr  <= '0;
      mem_wdata <= '0;
      owner     <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        mem_cmd   <= grant1 ? m1_cmd   : m0_cmd;
        mem_addr  <= grant1 ? m1_addr  : m0_addr;
        mem_wdata <= grant1 ? m1_wdata : m0_wdata;
        owner     <= grant1;
      end else begin
        mem_cmd <= MNONE;
      end
    end
  end

  assign m0_rvalid = (state == S_RESP) && !owner;
  assign m1_rvalid = (state == S_RESP) &&  owner;
  assign m0_rdata  = mem_rdata;
  assign m1_rdata  = mem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - randomized and directed check of mem_port_arbiter against a transaction model
module tb_mem_port_arbiter;
  localparam int AW = 9;
  localparam int DW = 16;
  localparam logic [2:0] MNONE  = 3'b001;
  localparam logic [2:0] MREAD  = 3'b010;
  localparam logic [2:0] MWRITE = 3'b100;

  logic          clk = 1'b0;
  logic          reset;
  logic [2:0]    m0_cmd, m1_cmd;
  logic [AW-1:0] m0_addr, m1_addr;
  logic [DW-1:0] m0_wdata, m1_wdata;
  logic          m0_ready, m1_ready, m0_rvalid, m1_rvalid;
  logic [DW-1:0] m0_rdata, m1_rdata;
  logic [2:0]    mem_cmd;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  always #5 clk = ~clk;

  mem_port_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .reset(reset),
    .m0_cmd(m0_cmd), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_ready(m0_ready), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_cmd(m1_cmd), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_ready(m1_ready), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .mem_cmd(mem_cmd), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  // Synchronous RAM behind the arbiter.
  logic [DW-1:0] ram [0:511];
  always @(posedge clk) begin
    if (mem_cmd == MWRITE) ram[mem_addr] <= mem_wdata;
    if (mem_cmd == MREAD)  mem_rdata <= ram[mem_addr];
  end

  // Transaction-level reference: cycle numbers of pending events, not FSM states.
  int            total = 0;
  int            bad = 0;
  int            cyc = 0;
  int            free_at = 0;
  int            acc_cyc = -1;
  logic [2:0]    acc_cmd = MNONE;
  int            rv_cyc = -1;
  int            rv_owner = 0;
  logic [DW-1:0] rv_data = '0;
  bit            rv_known = 0;
  logic [AW-1:0] hold_addr = '0;
  logic [DW-1:0] hold_wdata = '0;
  logic [DW-1:0] ref_mem [0:511];
  bit            ref_known [0:511];
  int            rr_next = 0;
  int            last_grant = -1;

  function automatic bit is_req(input logic [2:0] c);
    return (c == MREAD) || (c == MWRITE);
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  // Apply one cycle of inputs, compare outputs with the model, advance across the clock edge.
  task automatic step(input bit rst,
                      input logic [2:0] c0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                      input logic [2:0] c1, input logic [AW-1:0] a1, input logic [DW-1:0] d1);
    int win;
    logic [2:0]    wc;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    reset = rst;
    m0_cmd = c0; m0_addr = a0; m0_wdata = d0;
    m1_cmd = c1; m1_addr = a1; m1_wdata = d1;
    #1;
    win = -1;
    if (!rst && cyc >= free_at) begin
      if (is_req(c0) && is_req(c1)) begin
`ifdef MEM_ARB_RR_EN
        win = rr_next;
`else
        win = 0;
`endif
      end else if (is_req(c0)) win = 0;
      else if (is_req(c1)) win = 1;
    end
    check("m0_ready", {31'd0, m0_ready}, {31'd0, win == 0});
    check("m1_ready", {31'd0, m1_ready}, {31'd0, win == 1});
    check("mem_cmd", {29'd0, mem_cmd}, {29'd0, (cyc == acc_cyc) ? acc_cmd : MNONE});
    check("mem_addr", {23'd0, mem_addr}, {23'd0, hold_addr});
    check("mem_wdata", {16'd0, mem_wdata}, {16'd0, hold_wdata});
    check("m0_rvalid", {31'd0, m0_rvalid}, {31'd0, cyc == rv_cyc && rv_owner == 0});
    check("m1_rvalid", {31'd0, m1_rvalid}, {31'd0, cyc == rv_cyc && rv_owner == 1});
    if (cyc == rv_cyc && rv_known)
      check("rdata", {16'd0, (rv_owner == 0) ? m0_rdata : m1_rdata}, {16'd0, rv_data});

    last_grant = win;
    if (rst) begin
      free_at = cyc + 1; acc_cyc = -1; rv_cyc = -1;
      hold_addr = '0; hold_wdata = '0; rr_next = 0;
    end else if (win >= 0) begin
      wc = (win == 0) ? c0 : c1;
      wa = (win == 0) ? a0 : a1;
      wd = (win == 0) ? d0 : d1;
      acc_cyc = cyc + 1; acc_cmd = wc;
      hold_addr = wa; hold_wdata = wd;
      if (wc == MREAD) begin
        rv_cyc = cyc + 2; rv_owner = win;
        rv_data = ref_mem[wa]; rv_known = ref_known[wa];
        free_at = cyc + 3;
      end else begin
        ref_mem[wa] = wd; ref_known[wa] = 1;
        free_at = cyc + 2;
      end
      rr_next = 1 - win;
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, MNONE, '0, '0, MNONE, '0, '0);
  endtask

  logic [2:0]    rc [2];
  logic [AW-1:0] ra [2];
  logic [DW-1:0] rd [2];

  initial begin
    reset = 1'b1;
    m0_cmd = MNONE; m0_addr = '0; m0_wdata = '0;
    m1_cmd = MNONE; m1_addr = '0; m1_wdata = '0;
    for (int i = 0; i < 512; i++) ref_mem[i] = '0;
    @(negedge clk);
    @(negedge clk);

    // Reset held two cycles, then idle state with MNONE on the RAM.
    step(1, MNONE, '0, '0, MNONE, '0, '0);
    step(1, MNONE, '0, '0, MNONE, '0, '0);
    idle(2);

    // Single read after a write of BEEF.
    step(0, MWRITE, 9'h05, 16'hBEEF, MNONE, '0, '0);
    idle(1);
    step(0, MREAD, 9'h05, '0, MNONE, '0, '0);
    idle(3);

    // Simultaneous requests.
    step(0, MREAD, 9'h01, '0, MWRITE, 9'h02, 16'h1234);
    step(0, MNONE, '0, '0, MWRITE, 9'h02, 16'h1234);
    step(0, MNONE, '0, '0, MWRITE, 9'h02, 16'h1234);
    step(0, MNONE, '0, '0, MWRITE, 9'h02, 16'h1234);
    idle(2);
    check("ram2", {16'd0, ram[2]}, 32'h1234);
    step(0, MREAD, 9'h02, '0, MNONE, '0, '0);
    idle(3);

    // Both requesters streaming writes.
    for (int i = 0; i < 12; i++)
      step(0, MWRITE, 9'(16 + i), 16'(i), MWRITE, 9'(32 + i), 16'(100 + i));
    idle(2);

    // Reset while a read is in its RAM cycle.
    step(0, MNONE, '0, '0, MREAD, 9'h07, '0);
    step(1, MNONE, '0, '0, MNONE, '0, '0);
    idle(3);

    // Illegal code held, then a read withdrawn while the port is busy.
    for (int i = 0; i < 5; i++) step(0, 3'b110, 9'h03, 16'h5555, MNONE, '0, '0);
    step(0, MREAD, 9'h05, '0, MNONE, '0, '0);
    step(0, MNONE, '0, '0, MREAD, 9'h09, '0);
    step(0, MNONE, '0, '0, MNONE, '0, '0);
    idle(4);

    // Randomized traffic with protocol-following requesters.
    for (int k = 0; k < 2; k++) begin rc[k] = MNONE; ra[k] = '0; rd[k] = '0; end
    for (int n = 0; n < 3000; n++) begin
      for (int k = 0; k < 2; k++) begin
        if (last_grant == k || !is_req(rc[k])) begin
          int r;
          r = $urandom_range(0, 99);
          if (r < 35) rc[k] = MNONE;
          else if (r < 45) begin
            rc[k] = 3'($urandom_range(0, 7));
            if (is_req(rc[k])) rc[k] = 3'b000;
          end
          else if (r < 72) rc[k] = MREAD;
          else rc[k] = MWRITE;
          ra[k] = 9'($urandom_range(0, 15));
          rd[k] = 16'($urandom);
        end else if ($urandom_range(0, 19) == 0) begin
          rc[k] = MNONE;
        end
      end
      step($urandom_range(0, 49) == 0, rc[0], ra[0], rd[0], rc[1], ra[1], rd[1]);
    end
    idle(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter sharing the single synchronous RAM port between the CPU (requester 0) and the I/O / program-loader port (requester 1). It accepts one-hot memory commands (MNONE=3'b001, MREAD=3'b010, MWRITE=3'b100) from each requester and grants one access at a time. It drives a registered address, data and command onto the RAM and returns read data with a one-cycle valid strobe. It sits between `cpu`/loader and the RAM in the top level.

## Interface
- AW, 9, address width (matches `mem_addr`)
- DW, 16, data width
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- m0_cmd  in  3  requester 0 command, one-hot MNONE/MREAD/MWRITE
- m0_addr  in  AW  requester 0 address
- m0_wdata  in  DW  requester 0 write data
- m0_ready  out  1  request accepted this cycle (combinational)
- m0_rvalid  out  1  read data valid on m0_rdata
- m0_rdata  out  DW  read data
- m1_cmd, m1_addr, m1_wdata, m1_ready, m1_rvalid, m1_rdata: same as m0_* for requester 1
- mem_cmd  out  3  RAM command, one-hot
- mem_addr  out  AW  RAM address
- mem_wdata  out  DW  RAM write data
- mem_rdata  in  DW  RAM read data, valid the cycle after MREAD is presented

Reset is synchronous, active-high (`reset`); clock is `clk`.

## Operation
- Request active when cmd == MREAD or MWRITE. Every other code (MNONE, 000, multi-hot) is no request.
- FSM states:
  - S_IDLE: arbitrate. If a winner exists, assert its `mX_ready`, register its cmd/addr/wdata onto `mem_*`, record owner, go to S_ACC. Otherwise stay.
  - S_ACC: `mem_cmd` = latched command. Next state is S_RESP for MREAD, S_IDLE for MWRITE.
  - S_RESP: `mem_cmd` = MNONE, `mem_addr` held, owner's `mX_rvalid` = 1, go to S_IDLE.
- `m0_rdata` and `m1_rdata` are both wired to `mem_rdata`. They are meaningful only while the matching `rvalid` is high.
- Only one `ready` is ever high in a cycle. At most one `rvalid` is high per cycle, and only for the owner.
- Requester protocol:
  - Hold cmd/addr/wdata stable until `ready`, then present the next request or MNONE.
  - Withdrawing a request before `ready` is legal and produces no access.
- Requests arriving in S_ACC/S_RESP wait. No `ready` is asserted outside S_IDLE.
- Arbitration (default): fixed priority, requester 0 wins ties.
- `mem_cmd` = MNONE in every state except S_ACC.

## Timing
- Reset values:
  - state = S_IDLE
  - mem_cmd = 3'b001
  - mem_addr = 0, mem_wdata = 0
  - owner = 0, rr pointer = 1 (requester 0 next)
  - all ready = 0, all rvalid = 0
- Reset in any state aborts the access. `mem_cmd` is MNONE the cycle after reset is sampled, and no `rvalid` fires for an aborted read.
- Write: request and `ready` in cycle T; RAM write in T+1; new request can be accepted in T+2. That is 2 cycles per write.
- Read: `ready` in T; MREAD on `mem_*` in T+1; `rvalid` with data in T+2; next accept in T+3. That is 3 cycles per read.
- Simultaneous requests in S_IDLE: the winner is granted that cycle. The loser is granted at the next S_IDLE if its request is still held.

## Configuration
- MEM_ARB_RR_EN defined: round-robin arbitration.
  - On a tie, the requester not granted last wins.
  - The rr pointer updates on every `ready`.
  - Single requests are granted regardless of the pointer.
- MEM_ARB_RR_EN undefined: fixed priority, requester 0 always wins ties. The pointer logic is not compiled.

## Test plan
- Reset: assert `reset` 2 cycles. Check mem_cmd=001, mem_addr=0, both ready/rvalid=0, and state S_IDLE after release.
- Single read: write 16'hBEEF at 9'h05, then m0 MREAD at 9'h05. Check m0_ready in T, mem_cmd=010 with mem_addr=9'h05 in T+1, and m0_rvalid=1 with m0_rdata=16'hBEEF in T+2. m1_rvalid stays 0.
- Tie, fixed priority (macro off): m0 MREAD 9'h01 and m1 MWRITE 9'h02/16'h1234 in the same cycle. Check that m0 is served first and m1_ready comes at T+3. RAM[2]=16'h1234 after.
- Tie, round-robin (macro on): both requesters hold continuous MWRITEs. Check that grants alternate m0, m1, m0, m1 with a `ready` every 2 cycles.
- Reset mid-read: m1 MREAD accepted, `reset` asserted in S_ACC. Check mem_cmd=001 next cycle and no m1_rvalid pulse.
- Illegal/withdrawn command: m0_cmd=3'b110 for 5 cycles, then m1 raises MREAD and drops it before being granted while busy. Check that no `ready` is asserted and no non-MNONE `mem_cmd` appears for those requests.
